// File: rtl/hazard_bypass_ctrl_if.sv
// Decode-stage hazard query bus: decode instruction fields in, bypass selects and stall controls out.
interface hazard_bypass_ctrl_if #(
  parameter int AW        = 5,
  parameter int CNT_WIDTH = 16
);
  logic                 i_d_valid;
  logic [AW-1:0]        i_d_rs1_addr;
  logic [AW-1:0]        i_d_rs2_addr;
  logic                 i_d_valid_rs1;
  logic                 i_d_valid_rs2;
  logic [AW-1:0]        i_d_rd_addr;
  logic                 i_d_rf_wr_en;
  logic                 i_d_is_load;
  logic                 i_flush;
  logic                 i_hold;
  logic                 o_bypass_from_exe_valid_rs1;
  logic                 o_bypass_from_exe_valid_rs2;
  logic                 o_bypass_from_mem_valid_rs1;
  logic                 o_bypass_from_mem_valid_rs2;
  logic                 o_bypass_from_wb_valid_rs1;
  logic                 o_bypass_from_wb_valid_rs2;
  logic                 o_stall_fd;
  logic                 o_bubble_ex;
  logic [CNT_WIDTH-1:0] o_loaduse_cnt;

  modport master (
    output i_d_valid, i_d_rs1_addr, i_d_rs2_addr, i_d_valid_rs1, i_d_valid_rs2,
           i_d_rd_addr, i_d_rf_wr_en, i_d_is_load, i_flush, i_hold,
    input  o_bypass_from_exe_valid_rs1, o_bypass_from_exe_valid_rs2,
           o_bypass_from_mem_valid_rs1, o_bypass_from_mem_valid_rs2,
           o_bypass_from_wb_valid_rs1, o_bypass_from_wb_valid_rs2,
           o_stall_fd, o_bubble_ex, o_loaduse_cnt
  );

  modport slave (
    input  i_d_valid, i_d_rs1_addr, i_d_rs2_addr, i_d_valid_rs1, i_d_valid_rs2,
           i_d_rd_addr, i_d_rf_wr_en, i_d_is_load, i_flush, i_hold,
    output o_bypass_from_exe_valid_rs1, o_bypass_from_exe_valid_rs2,
           o_bypass_from_mem_valid_rs1, o_bypass_from_mem_valid_rs2,
           o_bypass_from_wb_valid_rs1, o_bypass_from_wb_valid_rs2,
           o_stall_fd, o_bubble_ex, o_loaduse_cnt
  );
endinterface

// File: rtl/hazard_bypass_ctrl.sv
// Operand bypass selection and load-use stall control for the decode stage,
// driven by a 3-entry shadow of the EXE/MEM/WB destination info.
module hazard_bypass_ctrl #(
  parameter int REG_NUM   = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  hazard_bypass_ctrl_if.slave  bus
);
  localparam int AW = $clog2(REG_NUM);

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] rd;
    logic          wr;
    logic          ld;
  } stage_t;

  stage_t               ex_q, mem_q, wb_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic m_ex1, m_ex2, m_mem1, m_mem2, m_wb1, m_wb2;
  logic lu, stall, bubble;

  // x0 is never a live producer, and bubble entries never match whatever rd they carry.
  function automatic logic src_match(input stage_t s, input logic [AW-1:0] a, input logic rd_en);
    return bus.i_d_valid & rd_en & s.vld & s.wr & (s.rd != '0) & (s.rd == a);
  endfunction

  always_comb begin
    m_ex1  = src_match(ex_q,  bus.i_d_rs1_addr, bus.i_d_valid_rs1);
    m_ex2  = src_match(ex_q,  bus.i_d_rs2_addr, bus.i_d_valid_rs2);
    m_mem1 = src_match(mem_q, bus.i_d_rs1_addr, bus.i_d_valid_rs1);
    m_mem2 = src_match(mem_q, bus.i_d_rs2_addr, bus.i_d_valid_rs2);
    m_wb1  = src_match(wb_q,  bus.i_d_rs1_addr, bus.i_d_valid_rs1);
    m_wb2  = src_match(wb_q,  bus.i_d_rs2_addr, bus.i_d_valid_rs2);
    lu     = (m_ex1 | m_ex2) & ex_q.ld;
    stall  = lu & ~bus.i_flush & i_rst_n;
    bubble = (lu | bus.i_flush) & i_rst_n;
  end

  // Gating with i_rst_n keeps every output low while reset is asserted, even if flush is driven.
  assign bus.o_bypass_from_exe_valid_rs1 = m_ex1 & ~ex_q.ld & i_rst_n;
  assign bus.o_bypass_from_exe_valid_rs2 = m_ex2 & ~ex_q.ld & i_rst_n;
  assign bus.o_bypass_from_mem_valid_rs1 = m_mem1 & ~m_ex1 & i_rst_n;
  assign bus.o_bypass_from_mem_valid_rs2 = m_mem2 & ~m_ex2 & i_rst_n;
  assign bus.o_bypass_from_wb_valid_rs1  = m_wb1 & ~m_ex1 & ~m_mem1 & i_rst_n;
  assign bus.o_bypass_from_wb_valid_rs2  = m_wb2 & ~m_ex2 & ~m_mem2 & i_rst_n;
  assign bus.o_stall_fd                  = stall;
  assign bus.o_bubble_ex                 = bubble;
  assign bus.o_loaduse_cnt               = cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else if (!bus.i_hold) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble)
        ex_q <= '0;
      else
        ex_q <= '{vld: bus.i_d_valid, rd: bus.i_d_rd_addr,
                  wr: bus.i_d_rf_wr_en, ld: bus.i_d_is_load};
      if (stall && (cnt_q != {CNT_WIDTH{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_bypass_ctrl.sv
// Directed-vector bench for hazard_bypass_ctrl: inputs driven on the falling edge, outputs checked 1ns later.
module tb_hazard_bypass_ctrl;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hazard_bypass_ctrl_if #(.AW(5), .CNT_WIDTH(16)) bus ();

  hazard_bypass_ctrl #(.REG_NUM(32), .CNT_WIDTH(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {exe1, exe2, mem1, mem2, wb1, wb2, stall_fd, bubble_ex}
  function automatic logic [31:0] outs();
    return {24'd0,
            bus.o_bypass_from_exe_valid_rs1, bus.o_bypass_from_exe_valid_rs2,
            bus.o_bypass_from_mem_valid_rs1, bus.o_bypass_from_mem_valid_rs2,
            bus.o_bypass_from_wb_valid_rs1,  bus.o_bypass_from_wb_valid_rs2,
            bus.o_stall_fd, bus.o_bubble_ex};
  endfunction

  task automatic drv(input logic v, input logic [4:0] r1, input logic v1,
                     input logic [4:0] r2, input logic v2, input logic [4:0] rd,
                     input logic wr, input logic ld, input logic fl, input logic hd);
    bus.i_d_valid     = v;
    bus.i_d_rs1_addr  = r1;
    bus.i_d_valid_rs1 = v1;
    bus.i_d_rs2_addr  = r2;
    bus.i_d_valid_rs2 = v2;
    bus.i_d_rd_addr   = rd;
    bus.i_d_rf_wr_en  = wr;
    bus.i_d_is_load   = ld;
    bus.i_flush       = fl;
    bus.i_hold        = hd;
  endtask

  task automatic step(input logic v, input logic [4:0] r1, input logic v1,
                      input logic [4:0] r2, input logic v2, input logic [4:0] rd,
                      input logic wr, input logic ld, input logic fl, input logic hd);
    @(negedge clk);
    drv(v, r1, v1, r2, v2, rd, wr, ld, fl, hd);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    chk("reset_outs", outs(), 32'h00);
    chk("reset_cnt", 32'(bus.o_loaduse_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x5 ; add x6,x5,x5
    step(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0);
    chk("addi_x5", outs(), 32'h00);
    step(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0);
    chk("exe_fwd_both", outs(), 32'hC0);

    // lw x7 ; add x8,x7,x0
    step(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0);
    chk("lw_x7", outs(), 32'h00);
    step(1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0);
    chk("loaduse_stall", outs(), 32'h03);
    chk("cnt_before", 32'(bus.o_loaduse_cnt), 32'd0);
    step(1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0);
    chk("loaduse_resolve", outs(), 32'h20);
    chk("cnt_after_lu", 32'(bus.o_loaduse_cnt), 32'd1);

    // x3 written in EX, MEM and WB at once
    step(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0);
    chk("addi_x3_a", outs(), 32'h00);
    step(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0);
    step(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 0);
    step(1, 5'd3, 1, 5'd3, 0, 5'd0, 0, 0, 0, 0);
    chk("x3_onehot_exe", outs(), 32'h80);
    step(1, 5'd0, 0, 5'd3, 1, 5'd0, 0, 0, 0, 0);
    chk("x3_mem_over_wb", outs(), 32'h10);
    step(1, 5'd3, 1, 5'd3, 1, 5'd0, 0, 0, 0, 0);
    chk("x3_wb_only", outs(), 32'h0C);

    // addi x0,x0,1 ; add x1,x0,x0
    step(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0);
    chk("x0_write", outs(), 32'h00);
    step(1, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0, 0, 0);
    chk("x0_guard", outs(), 32'h00);

    // lw x9 ; dependent with flush in the same cycle
    step(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0, 0);
    chk("lw_x9", outs(), 32'h00);
    step(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0, 1, 0);
    chk("flush_wins", outs(), 32'h01);
    step(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    chk("flush_cnt", 32'(bus.o_loaduse_cnt), 32'd1);
    chk("load_in_mem", outs(), 32'h20);

    // lw x11 ; dependent frozen by hold for 3 cycles
    step(1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 5'd11, 1, 5'd0, 0, 5'd12, 1, 0, 0, 1);
      chk("hold_stall", outs(), 32'h03);
    end
    chk("hold_cnt", 32'(bus.o_loaduse_cnt), 32'd1);
    step(1, 5'd11, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0);
    chk("hold_release", outs(), 32'h03);
    step(1, 5'd11, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0);
    chk("hold_resolve", outs(), 32'h20);
    chk("cnt_two", 32'(bus.o_loaduse_cnt), 32'd2);

    // async reset mid-operation, flush driven to check output gating
    bus.i_flush = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", outs(), 32'h00);
    chk("async_rst_cnt", 32'(bus.o_loaduse_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 5'd11, 1, 5'd7, 1, 5'd0, 0, 0, 0, 0);
    chk("post_rst_clear", outs(), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
